if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. Sits directly upstream of the instruction memory.
- Owns the PC register and drives the memory word address. Captures the returned instruction into the IF/ID pipeline register.
- Computes the next PC from redirect controls supplied by ID: sequential, branch, j/jal, jr.
- Branch delay slot architecture: the instruction fetched during a redirect is never flushed.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; base of instruction memory.
- IM_WORDS, 2048, instruction memory depth in words; legal PC range is PC_RESET .. PC_RESET+4*IM_WORDS-4.
- NOP_WORD, 32'h0000_0000, instruction injected into IF/ID on a fault.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc  out  32  current fetch PC; pc[12:2] drives the instruction memory address
- im_dout  in  32  instruction word returned combinationally for pc
- stall  in  1  hazard hold from ID; freezes PC and IF/ID
- npc_sel  in  2  00 SEQ, 01 BR, 10 J, 11 JR; issued by ID for the instruction in IF/ID
- br_taken  in  1  branch comparison result; only meaningful when npc_sel=BR
- br_off  in  16  branch imm16
- j_index  in  26  jump instr_index
- jr_target  in  32  rs value for jr/jalr
- ifid_instr  out  32  registered instruction
- ifid_pc  out  32  registered PC of ifid_instr
- ifid_pc8  out  32  ifid_pc+8 (link value for jal/jalr)
- ifid_valid  out  1  IF/ID holds a real fetched instruction
- fault  out  1  sticky fetch fault flag
- fault_pc  out  32  PC that caused the fault

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - pc=PC_RESET; ifid_instr=0, ifid_pc=0, ifid_pc8=0, ifid_valid=0; fault=0, fault_pc=0.
  - State=RUN.
- States:
  - RUN -> HALT on a fault at an unstalled edge.
  - HALT -> RUN only via rst.
- Next-PC (combinational), with p4 = ifid_pc+4:
  - SEQ: pc+4.
  - BR: br_taken ? p4 + (sext(br_off)<<2) : pc+4.
  - J: {p4[31:28], j_index, 2'b00}.
  - JR: jr_target.
  - All adds are modulo 2^32.
- RUN, stall=0, pc legal, at the edge:
  - pc<=npc; ifid_instr<=im_dout; ifid_pc<=pc; ifid_pc8<=pc+8; ifid_valid<=1.
  - Latency: an instruction appears in IF/ID one cycle after its PC is presented.
- Redirect timing: a redirect decided in ID takes effect on the PC after the delay-slot fetch. The delay-slot instruction proceeds normally.
- stall=1: pc and all ifid_* hold; npc_sel is ignored. ID holds the same instruction, so the redirect is re-issued when the stall releases.
- Fault condition: pc[1:0]!=0, or pc < PC_RESET, or pc > PC_RESET+4*IM_WORDS-4. Evaluated on the current pc.
  - On the first unstalled RUN edge with a fault: fault<=1; fault_pc<=pc; ifid_instr<=NOP_WORD; ifid_valid<=0; ifid_pc/ifid_pc8 hold; pc holds; state<=HALT.
- HALT:
  - pc frozen; fault and fault_pc frozen.
  - Each unstalled edge loads ifid_instr=NOP_WORD and ifid_valid=0.
  - stall is still honoured.
- Wrap: pc+4 past 0xFFFF_FFFC yields 0, which is out of range and faults on the next edge.
- Simultaneous stall and fault: no transition until stall drops.
- Reset during a stall or in HALT: the reset values apply at that edge.

Decomposition:
- Shared package, cpu_defs:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings.
  - PC_RESET.
  - NOP_WORD.
  - State encoding RUN/HALT.
- One sub-module, npc_calc: purely combinational next-PC mux/adders (pc, ifid_pc, npc_sel, br_taken, br_off, j_index, jr_target -> npc).
- The PC register, IF/ID register, fault logic and FSM stay in if_stage.

Test Plan:
1. Release rst; memory returns 0x11111111/0x22222222/0x33333333 for words 0..2.
   -> pc goes 0x3000, 0x3004, 0x3008 on successive edges.
   -> After the first edge: ifid_instr=0x11111111, ifid_pc=0x3000, ifid_pc8=0x3008, ifid_valid=1.
2. Taken branch: ifid_pc=0x3004, pc=0x3008, npc_sel=BR, br_taken=1, br_off=0xFFFF.
   -> pc becomes 0x3004.
   -> The delay slot at 0x3008 enters IF/ID with valid=1.
   -> Repeat with br_taken=0: pc becomes 0x300C.
3. Jumps:
   -> J with ifid_pc=0x3000, j_index=0x0000C05 -> pc=0x0000_3014.
   -> JR with jr_target=0x0000_3020 -> pc=0x3020.
4. Stall held 2 cycles while npc_sel=J.
   -> pc and ifid_* unchanged for both cycles.
   -> On the first unstalled edge, pc takes the jump target.
5. Faults:
   -> JR to 0x0000_3002: pc=0x3002, then fault=1, fault_pc=0x3002, ifid_instr=0, ifid_valid=0, pc stuck.
   -> Repeat with jr_target=0x0000_5000 (out of range): same response.
   -> rst clears fault and restarts at 0x3000.
6. rst asserted while stall=1 and in HALT.
   -> All outputs take their reset values at that edge.
   -> Fetch resumes from 0x3000 after release.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the fetch path: next-PC select encodings, memory base,
// the bubble instruction and the fetch FSM states.
package cpu_defs;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          IM_WORDS = 2048;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // Branch immediate is a word offset: sign-extend and scale to bytes.
  function automatic logic [31:0] br_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection. Redirect targets are relative to the
// instruction held in IF/ID, since that is the one ID has decoded.
module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ifid_pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] br_off,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] p4;

  assign seq_pc = pc + 32'd4;
  assign p4     = ifid_pc + 32'd4;

  always_comb begin
    npc = seq_pc;
    case (npc_sel)
      NPC_SEQ: npc = seq_pc;
      NPC_BR:  npc = br_taken ? (p4 + br_disp(br_off)) : seq_pc;
      NPC_J:   npc = {p4[31:28], j_index, 2'b00};
      NPC_JR:  npc = jr_target;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a sticky
// fetch-fault detector that parks the stage in HALT until reset.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 2048,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] im_dout,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] br_off,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc8,
  output logic        ifid_valid,
  output logic        fault,
  output logic [31:0] fault_pc
);

  import cpu_defs::*;

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

  state_e      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_pc8_reg, ifid_pc8_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic        fault_reg, fault_next;
  logic [31:0] fault_pc_reg, fault_pc_next;

  logic [31:0] npc;
  logic        pc_bad;

  npc_calc u_npc_calc (
    .pc        (pc_reg),
    .ifid_pc   (ifid_pc_reg),
    .npc_sel   (npc_sel),
    .br_taken  (br_taken),
    .br_off    (br_off),
    .j_index   (j_index),
    .jr_target (jr_target),
    .npc       (npc)
  );

  // Checked on the PC being presented now, so a bad target is fetched-at once
  // and reported on the following unstalled edge.
  assign pc_bad = (pc_reg[1:0] != 2'b00) || (pc_reg < PC_RESET) || (pc_reg > PC_LAST);

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_pc_next    = ifid_pc_reg;
    ifid_pc8_next   = ifid_pc8_reg;
    ifid_valid_next = ifid_valid_reg;
    fault_next      = fault_reg;
    fault_pc_next   = fault_pc_reg;

    if (!stall) begin
      case (state_reg)
        RUN: begin
          if (pc_bad) begin
            state_next      = HALT;
            fault_next      = 1'b1;
            fault_pc_next   = pc_reg;
            ifid_instr_next = NOP_WORD;
            ifid_valid_next = 1'b0;
          end else begin
            pc_next         = npc;
            ifid_instr_next = im_dout;
            ifid_pc_next    = pc_reg;
            ifid_pc8_next   = pc_reg + 32'd8;
            ifid_valid_next = 1'b1;
          end
        end
        HALT: begin
          // Keep feeding bubbles so nothing downstream sees a stale instruction.
          ifid_instr_next = NOP_WORD;
          ifid_valid_next = 1'b0;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      pc_reg         <= PC_RESET;
      ifid_instr_reg <= 32'd0;
      ifid_pc_reg    <= 32'd0;
      ifid_pc8_reg   <= 32'd0;
      ifid_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
      fault_pc_reg   <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_pc8_reg   <= ifid_pc8_next;
      ifid_valid_reg <= ifid_valid_next;
      fault_reg      <= fault_next;
      fault_pc_reg   <= fault_pc_next;
    end
  end

  assign pc         = pc_reg;
  assign ifid_instr = ifid_instr_reg;
  assign ifid_pc    = ifid_pc_reg;
  assign ifid_pc8   = ifid_pc8_reg;
  assign ifid_valid = ifid_valid_reg;
  assign fault      = fault_reg;
  assign fault_pc   = fault_pc_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step drives one cycle of ID controls and
// queues the hand-computed post-edge state; a monitor pops and compares.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] im_dout;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] br_off;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc8, fault_pc;
  logic        ifid_valid, fault;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc8;
    logic        valid;
    logic        fault;
    logic [31:0] fpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .im_dout    (im_dout),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .br_off     (br_off),
    .j_index    (j_index),
    .jr_target  (jr_target),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_pc8   (ifid_pc8),
    .ifid_valid (ifid_valid),
    .fault      (fault),
    .fault_pc   (fault_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory model: words 0..2 of the image hold fixed patterns,
  // every other word returns a tag of its own word address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [10:0] w;
    w = a[12:2];
    case (w)
      11'h400: return 32'h1111_1111;
      11'h401: return 32'h2222_2222;
      11'h402: return 32'h3333_3333;
      default: return 32'hC000_0000 | {21'd0, w};
    endcase
  endfunction

  assign im_dout = imem(pc);

  localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, J = 2'b10, JR = 2'b11;

  task automatic step(input string nm, input logic r, input logic s, input logic [1:0] sel,
                      input logic tk, input logic [15:0] off, input logic [25:0] ji,
                      input logic [31:0] jt, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_ipc, input logic [31:0] e_ipc8, input logic e_v,
                      input logic e_f, input logic [31:0] e_fpc);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; npc_sel = sel; br_taken = tk;
    br_off = off; j_index = ji; jr_target = jt;
    e.name = nm; e.pc = e_pc; e.instr = e_instr; e.ipc = e_ipc; e.ipc8 = e_ipc8;
    e.valid = e_v; e.fault = e_f; e.fpc = e_fpc;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge for which an expectation was queued is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e.pc || ifid_instr !== e.instr || ifid_pc !== e.ipc || ifid_pc8 !== e.ipc8 ||
            ifid_valid !== e.valid || fault !== e.fault || fault_pc !== e.fpc) begin
          n_fail++;
          $display("FAIL %s: got pc=%h instr=%h ipc=%h ipc8=%h v=%b f=%b fpc=%h, want pc=%h instr=%h ipc=%h ipc8=%h v=%b f=%b fpc=%h",
                   e.name, pc, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, fault, fault_pc,
                   e.pc, e.instr, e.ipc, e.ipc8, e.valid, e.fault, e.fpc);
        end else begin
          $display("ok   %s: pc=%h instr=%h ipc=%h v=%b f=%b", e.name, pc, ifid_instr, ifid_pc,
                   ifid_valid, fault);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; npc_sel = SEQ; br_taken = 1'b0;
    br_off = 16'h0; j_index = 26'h0; jr_target = 32'h0;

    //    name          rst stl sel tk off      jidx       jr            pc        instr         ipc       ipc8      v f fpc
    step("reset",       1, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3000, 32'h0,        32'h0,    32'h0,    0,0,32'h0);
    step("seq0",        0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3004, 32'h1111_1111,32'h3000, 32'h3008, 1,0,32'h0);
    step("seq1",        0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3008, 32'h2222_2222,32'h3004, 32'h300C, 1,0,32'h0);
    step("br_taken",    0, 0, BR,  1, 16'hFFFF, 26'h0,     32'h0,    32'h3004, 32'h3333_3333,32'h3008, 32'h3010, 1,0,32'h0);
    step("seq2",        0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3008, 32'h2222_2222,32'h3004, 32'h300C, 1,0,32'h0);
    step("br_not",      0, 0, BR,  0, 16'hFFFF, 26'h0,     32'h0,    32'h300C, 32'h3333_3333,32'h3008, 32'h3010, 1,0,32'h0);
    step("jr_3000",     0, 0, JR,  0, 16'h0,    26'h0,     32'h3000, 32'h3000, 32'hC000_0403,32'h300C, 32'h3014, 1,0,32'h0);
    step("seq3",        0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3004, 32'h1111_1111,32'h3000, 32'h3008, 1,0,32'h0);
    step("j_c05",       0, 0, J,   0, 16'h0,    26'h0C05,  32'h0,    32'h3014, 32'h2222_2222,32'h3004, 32'h300C, 1,0,32'h0);
    step("jr_3020",     0, 0, JR,  0, 16'h0,    26'h0,     32'h3020, 32'h3020, 32'hC000_0405,32'h3014, 32'h301C, 1,0,32'h0);
    step("stall_j_a",   0, 1, J,   0, 16'h0,    26'h0C06,  32'h0,    32'h3020, 32'hC000_0405,32'h3014, 32'h301C, 1,0,32'h0);
    step("stall_j_b",   0, 1, J,   0, 16'h0,    26'h0C06,  32'h0,    32'h3020, 32'hC000_0405,32'h3014, 32'h301C, 1,0,32'h0);
    step("j_release",   0, 0, J,   0, 16'h0,    26'h0C06,  32'h0,    32'h3018, 32'hC000_0408,32'h3020, 32'h3028, 1,0,32'h0);
    step("jr_misalign", 0, 0, JR,  0, 16'h0,    26'h0,     32'h3002, 32'h3002, 32'hC000_0406,32'h3018, 32'h3020, 1,0,32'h0);
    step("fault_align", 0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3002, 32'h0,        32'h3018, 32'h3020, 0,1,32'h3002);
    step("halt_hold",   0, 0, JR,  0, 16'h0,    26'h0,     32'h3000, 32'h3002, 32'h0,        32'h3018, 32'h3020, 0,1,32'h3002);
    step("halt_stall",  0, 1, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3002, 32'h0,        32'h3018, 32'h3020, 0,1,32'h3002);
    step("reset_halt",  1, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3000, 32'h0,        32'h0,    32'h0,    0,0,32'h0);
    step("restart",     0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3004, 32'h1111_1111,32'h3000, 32'h3008, 1,0,32'h0);
    step("jr_last",     0, 0, JR,  0, 16'h0,    26'h0,     32'h4FFC, 32'h4FFC, 32'h2222_2222,32'h3004, 32'h300C, 1,0,32'h0);
    step("last_legal",  0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h5000, 32'hC000_03FF,32'h4FFC, 32'h5004, 1,0,32'h0);
    step("fault_high",  0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h5000, 32'h0,        32'h4FFC, 32'h5004, 0,1,32'h5000);
    step("rst_stl_hlt", 1, 1, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3000, 32'h0,        32'h0,    32'h0,    0,0,32'h0);
    step("resume0",     0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3004, 32'h1111_1111,32'h3000, 32'h3008, 1,0,32'h0);
    step("resume1",     0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3008, 32'h2222_2222,32'h3004, 32'h300C, 1,0,32'h0);
    step("jr_low",      0, 0, JR,  0, 16'h0,    26'h0,     32'h2FFC, 32'h2FFC, 32'h3333_3333,32'h3008, 32'h3010, 1,0,32'h0);
    step("stall_fault", 0, 1, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h2FFC, 32'h3333_3333,32'h3008, 32'h3010, 1,0,32'h0);
    step("fault_low",   0, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h2FFC, 32'h0,        32'h3008, 32'h3010, 0,1,32'h2FFC);
    step("final_rst",   1, 0, SEQ, 0, 16'h0,    26'h0,     32'h0,    32'h3000, 32'h0,        32'h0,    32'h0,    0,0,32'h0);

    stim_done = 1'b1;
  end

  // Bounded wait for the monitor to drain the scoreboard.
  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
